out_collect: RTL and testbench
==============================

# out_collect

Output-side collector for the PID pipeline. Accepts one result word per cycle from the pipeline tail as (valid, channel, data) and tags it with the channel's configured output destination. Queues tagged words in an internal FIFO. Presents them one at a time over a valid/ready handshake to the DAC/DDS serializer stage. This is the mirror of the input-side instruction dispatch: input routing fans sources out to channels, this block fans channel results back in to output devices.

## Interface
- W_CHAN, 5: channel number width
- N_CHAN, 8: number of PID channels
- W_DATA, 18: result data width
- W_DEST, 4: destination index width; encoding `{1'b1, W_DEST'b0}` of the W_DEST+1-bit config field is NULL
- N_DEST, 8: number of valid destinations
- W_DEPTH, 4: FIFO address width; depth is 2^W_DEPTH
- W_WR_ADDR, 16 / W_WR_CHAN, 16 / W_WR_DATA, 48: config write bus widths
- DEST_ADDR, 16'h0040: config address of the per-channel destination register
- OVF_CLR_ADDR, 16'h0041: config address whose write clears the overflow flag

Ports:
- clk_in  in  1  clock; all logic on posedge
- rst_n_in  in  1  reset; asynchronous, active-low
- dv_in  in  1  result valid from pipeline tail
- chan_in  in  W_CHAN  result channel
- data_in  in  W_DATA  result data
- wr_en  in  1  config write strobe
- wr_addr  in  W_WR_ADDR  config address
- wr_chan  in  W_WR_CHAN  config channel
- wr_data  in  W_WR_DATA  config data
- dv_out  out  1  output word valid
- rdy_in  in  1  serializer ready
- dest_out  out  W_DEST  destination of presented word
- chan_out  out  W_CHAN  source channel of presented word
- data_out  out  W_DATA  presented data
- ovf_out  out  1  sticky FIFO overflow flag
- drop_cnt_out  out  16  dropped-word counter (see Configuration)

## Operation
- dest_mem[N_CHAN] is W_DEST+1 bits wide. Reset value of every entry is NULL.
- A write with wr_en=1, wr_addr==DEST_ADDR and wr_chan<N_CHAN stores wr_data[W_DEST:0] into dest_mem[wr_chan].
- A write to OVF_CLR_ADDR clears ovf_out and drop_cnt_out. wr_chan is ignored for this write.
- Enqueue condition: dv_in=1, chan_in<N_CHAN, dest_mem[chan_in] not NULL, dest_mem[chan_in][W_DEST-1:0]<N_DEST, and FIFO not full.
  - The entry {dest, chan, data} is written using the destination as it stands in that cycle.
  - A later reconfiguration does not retag words already queued.
- Drop conditions: a dv_in word that is unmapped or has an out-of-range channel is silently dropped. A word dropped because the FIFO is full sets ovf_out.
- "Full" is evaluated before any same-cycle dequeue. An arriving word while full is dropped even if the head leaves in the same cycle.
- Output register FSM:
  - EMPTY: dv_out=0. When the FIFO is non-empty, load the head into the output register → VALID.
  - VALID: dv_out=1 and outputs are held stable. On dv_out&rdy_in the word is transferred. If the FIFO is non-empty, load the next head in the same cycle and stay in VALID; otherwise go to EMPTY.
- Words leave in arrival order. There is no per-destination reordering.

## Timing
- Reset (async assert, sync release): dv_out=0, dest_out=0, chan_out=0, data_out=0, ovf_out=0, drop_cnt_out=0, FIFO empty, FSM EMPTY, all dest_mem entries NULL.
- Latency from accepted dv_in at edge N to dv_out=1 with an empty FIFO and FSM EMPTY: the word is written at N and dv_out rises after edge N+1 (2-cycle path).
- Throughput: one word per cycle when rdy_in is held high.
- rdy_in is a don't-care while dv_out=0.
- A config write to dest_mem[c] in the same cycle as dv_in for channel c uses the old destination.
- Reset mid-transfer discards FIFO contents and the output register. No partial word is presented after release.

## Configuration
- OUT_COLLECT_DROP_CNT_EN defined: drop_cnt_out is a 16-bit counter.
  - Increments once per dropped dv_in word of any drop kind.
  - Saturates at 16'hFFFF.
  - Cleared by reset or by a write to OVF_CLR_ADDR.
- OUT_COLLECT_DROP_CNT_EN undefined: the counter logic is absent and drop_cnt_out is tied to 0. ovf_out behaves identically in both builds.

## Test plan
- Map ch2→dest 5; send dv_in ch2 data 18'h1234 with rdy_in=1 → dv_out two edges later with dest_out=5, chan_out=2, data_out=18'h1234, held for exactly one cycle.
- Leave ch3 NULL; send 3 words on ch3 → no dv_out, ovf_out=0, drop_cnt_out=3 (0 without the macro).
- Hold rdy_in=0; send 17 words with W_DEPTH=4 → first 17 accepted (16 in FIFO plus 1 in output register), then an 18th is dropped and ovf_out=1. Raise rdy_in → 17 words emerge in order. Write OVF_CLR_ADDR → ovf_out=0.
- Send word A on ch1 (dest 2); next cycle remap ch1→dest 7; send word B → A exits with dest 2, B with dest 7.
- Toggle rdy_in 1/0 every cycle over a 10-word burst → every word is presented exactly once, data is stable while rdy_in=0, and order is preserved.
- Assert rst_n_in low mid-burst for one cycle → dv_out drops to 0 immediately (asynchronous), FIFO is empty after release, and every dest_mem entry is NULL.

Source files
------------

// File: rtl/out_collect.sv
// -----------------------------------------------------------------------------
// out_collect
//
// Output-side collector for the PID pipeline. Result words arrive from the
// pipeline tail as (dv_in, chan_in, data_in). Each word is tagged with the
// output destination currently configured for its channel and is queued in a
// 2^W_DEPTH-entry FIFO. Tagged words are then presented one at a time to the
// DAC/DDS serializer over a valid/ready handshake. Words leave in arrival
// order.
//
// Ports
//   clk_in        : clock, all logic on posedge
//   rst_n_in      : asynchronous active-low reset
//   dv_in         : result valid from the pipeline tail
//   chan_in       : result channel
//   data_in       : result data
//   wr_en         : config write strobe
//   wr_addr       : config address (DEST_ADDR or OVF_CLR_ADDR)
//   wr_chan       : config channel (ignored for OVF_CLR_ADDR)
//   wr_data       : config data; [W_DEST:0] holds the destination field
//   dv_out        : output word valid
//   rdy_in        : serializer ready (don't-care while dv_out=0)
//   dest_out      : destination of the presented word
//   chan_out      : source channel of the presented word
//   data_out      : presented data
//   ovf_out       : sticky flag, set when a mapped word is lost to a full FIFO
//   drop_cnt_out  : saturating count of dropped dv_in words
//
// Build option
//   OUT_COLLECT_DROP_CNT_EN : when defined, drop_cnt_out is a live 16-bit
//   saturating counter; otherwise the counter is absent and the port is 0.
//
// Destination field encoding: {1'b1, W_DEST'b0} is NULL (channel unmapped).
// A non-NULL field whose low W_DEST bits are >= N_DEST is also unroutable.
// -----------------------------------------------------------------------------
module out_collect #(
  parameter int W_CHAN    = 5,
  parameter int N_CHAN    = 8,
  parameter int W_DATA    = 18,
  parameter int W_DEST    = 4,
  parameter int N_DEST    = 8,
  parameter int W_DEPTH   = 4,
  parameter int W_WR_ADDR = 16,
  parameter int W_WR_CHAN = 16,
  parameter int W_WR_DATA = 48,
  parameter logic [W_WR_ADDR-1:0] DEST_ADDR    = 16'h0040,
  parameter logic [W_WR_ADDR-1:0] OVF_CLR_ADDR = 16'h0041
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  // pipeline tail
  input  logic                 dv_in,
  input  logic [W_CHAN-1:0]    chan_in,
  input  logic [W_DATA-1:0]    data_in,
  // config bus
  input  logic                 wr_en,
  input  logic [W_WR_ADDR-1:0] wr_addr,
  input  logic [W_WR_CHAN-1:0] wr_chan,
  input  logic [W_WR_DATA-1:0] wr_data,
  // serializer side
  output logic                 dv_out,
  input  logic                 rdy_in,
  output logic [W_DEST-1:0]    dest_out,
  output logic [W_CHAN-1:0]    chan_out,
  output logic [W_DATA-1:0]    data_out,
  // status
  output logic                 ovf_out,
  output logic [15:0]          drop_cnt_out
);

  localparam int W_IDX = $clog2(N_CHAN);
  localparam int W_ENT = W_DEST + W_CHAN + W_DATA;
  localparam int DEPTH = 1 << W_DEPTH;

  localparam logic [W_DEST:0] DEST_NULL = {1'b1, {W_DEST{1'b0}}};

  // Output register FSM encoding
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_VALID = 1'b1;

  // ---------------------------------------------------------------------------
  // Config decode
  // ---------------------------------------------------------------------------
  logic w_wr_dest;
  logic w_ovf_clr;

  assign w_wr_dest = wr_en && (wr_addr == DEST_ADDR) &&
                     ({{(32-W_WR_CHAN){1'b0}}, wr_chan} < N_CHAN);
  assign w_ovf_clr = wr_en && (wr_addr == OVF_CLR_ADDR);

  // ---------------------------------------------------------------------------
  // Per-channel destination table
  // ---------------------------------------------------------------------------
  logic [W_DEST:0] r_dest_mem [N_CHAN];

  // NOTE: state is assigned with <= so every register samples the values that
  // held before the clock edge; '=' here would make results depend on the
  // order the simulator runs these blocks.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < N_CHAN; i++) begin
        r_dest_mem[i] <= DEST_NULL;
      end
    end else if (w_wr_dest) begin
      r_dest_mem[wr_chan[W_IDX-1:0]] <= wr_data[W_DEST:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Arrival classification. The lookup reads the table as it stands before
  // this edge, so a same-cycle config write affects only later words.
  // ---------------------------------------------------------------------------
  logic            w_chan_ok;
  logic [W_DEST:0] w_cur_dest;
  logic            w_mapped;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_drop;
  logic            w_drop_full;

  assign w_chan_ok  = ({{(32-W_CHAN){1'b0}}, chan_in} < N_CHAN);
  assign w_cur_dest = r_dest_mem[chan_in[W_IDX-1:0]];
  assign w_mapped   = w_chan_ok && (w_cur_dest != DEST_NULL) &&
                      ({{(32-W_DEST){1'b0}}, w_cur_dest[W_DEST-1:0]} < N_DEST);

  // Full is judged on the pre-edge pointers: a word arriving while full is
  // lost even if the head leaves on the same edge.
  assign w_push      = dv_in && w_mapped && !w_full;
  assign w_drop_full = dv_in && w_mapped && w_full;
  assign w_drop      = dv_in && !w_push;

  // ---------------------------------------------------------------------------
  // FIFO: pointers carry one extra wrap bit to tell full from empty.
  // ---------------------------------------------------------------------------
  logic [W_DEPTH:0]  r_wr_ptr;
  logic [W_DEPTH:0]  r_rd_ptr;
  logic [W_ENT-1:0]  r_fifo_mem [DEPTH];
  logic [W_ENT-1:0]  w_head;
  logic              w_pop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[W_DEPTH] != r_rd_ptr[W_DEPTH]) &&
                   (r_wr_ptr[W_DEPTH-1:0] == r_rd_ptr[W_DEPTH-1:0]);
  assign w_head  = r_fifo_mem[r_rd_ptr[W_DEPTH-1:0]];

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are live, and leaving the array unreset lets it map to RAM.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr[W_DEPTH-1:0]] <= {w_cur_dest[W_DEST-1:0], chan_in, data_in};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register FSM. The head is moved into the output register when the
  // register is free, or when its current word is taken this cycle, which
  // gives one word per cycle while rdy_in stays high.
  // ---------------------------------------------------------------------------
  logic [0:0] r_state;
  logic [0:0] w_state_nxt;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    w_pop       = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_VALID;
        end
      end
      ST_VALID: begin
        if (rdy_in) begin
          if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  logic [W_DEST-1:0] r_dest_out;
  logic [W_CHAN-1:0] r_chan_out;
  logic [W_DATA-1:0] r_data_out;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= ST_EMPTY;
      r_dest_out <= '0;
      r_chan_out <= '0;
      r_data_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        {r_dest_out, r_chan_out, r_data_out} <= w_head;
      end
    end
  end

  assign dv_out   = (r_state == ST_VALID);
  assign dest_out = r_dest_out;
  assign chan_out = r_chan_out;
  assign data_out = r_data_out;

  // ---------------------------------------------------------------------------
  // Status. A clear write takes priority over a drop on the same edge.
  // ---------------------------------------------------------------------------
  logic r_ovf;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end else if (w_drop_full) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf_out = r_ovf;

  // Config data above the destination field carries nothing for this block.
  logic w_unused;

`ifdef OUT_COLLECT_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_drop_cnt <= '0;
    end else if (w_ovf_clr) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt_out = r_drop_cnt;
  assign w_unused     = ^wr_data[W_WR_DATA-1:W_DEST+1];
`else
  assign drop_cnt_out = 16'd0;
  assign w_unused     = ^{wr_data[W_WR_DATA-1:W_DEST+1], w_drop};
`endif

endmodule

// File: tb/tb_out_collect.sv
// -----------------------------------------------------------------------------
// tb_out_collect
//
// Self-checking bench for out_collect. A queue-based reference model holds the
// destination table, the pending words and the presented word; after every
// clock edge the DUT outputs are compared with it. Directed sequences cover
// latency, unmapped channels, overflow, remapping, ready toggling and an
// asynchronous reset mid-burst, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_out_collect;

  localparam int N_CHAN = 8;
  localparam int N_DEST = 8;
  localparam int DEPTH  = 16;

`ifdef OUT_COLLECT_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk_in   = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        dv_in    = 1'b0;
  logic [4:0]  chan_in  = '0;
  logic [17:0] data_in  = '0;
  logic        wr_en    = 1'b0;
  logic [15:0] wr_addr  = '0;
  logic [15:0] wr_chan  = '0;
  logic [47:0] wr_data  = '0;
  logic        rdy_in   = 1'b0;
  logic        dv_out;
  logic [3:0]  dest_out;
  logic [4:0]  chan_out;
  logic [17:0] data_out;
  logic        ovf_out;
  logic [15:0] drop_cnt_out;

  out_collect dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .dv_in        (dv_in),
    .chan_in      (chan_in),
    .data_in      (data_in),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_chan      (wr_chan),
    .wr_data      (wr_data),
    .dv_out       (dv_out),
    .rdy_in       (rdy_in),
    .dest_out     (dest_out),
    .chan_out     (chan_out),
    .data_out     (data_out),
    .ovf_out      (ovf_out),
    .drop_cnt_out (drop_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [3:0]  dest;
    logic [4:0]  chan;
    logic [17:0] data;
  } word_t;

  logic [4:0] m_dest [N_CHAN];
  word_t      m_q[$];
  word_t      m_out;
  bit         m_vld;
  bit         m_ovf;
  int         m_cnt;
  word_t      obs[$];   // words actually handed over by the DUT

  task automatic model_reset();
    for (int i = 0; i < N_CHAN; i++) m_dest[i] = 5'h10;
    m_q.delete();
    m_vld = 1'b0;
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  function automatic logic [15:0] exp_cnt();
    return CNT_EN ? 16'(m_cnt) : 16'd0;
  endfunction

  // One clock: record any DUT handover, advance the model by the inputs that
  // are driven now, then compare all outputs 1 ns after the edge.
  task automatic step();
    bit    mapped, acc, drop, ovf_set;
    word_t w;
    if (dv_out && rdy_in) obs.push_back({dest_out, chan_out, data_out});
    @(posedge clk_in);
    acc = 0; drop = 0; ovf_set = 0; mapped = 0;
    w = '0;
    if (dv_in) begin
      if (int'(chan_in) < N_CHAN) begin
        w = {m_dest[chan_in[2:0]][3:0], chan_in, data_in};
        mapped = (m_dest[chan_in[2:0]] != 5'h10) &&
                 (int'(m_dest[chan_in[2:0]][3:0]) < N_DEST);
      end
      if (!mapped)                 drop = 1;
      else if (m_q.size() == DEPTH) begin drop = 1; ovf_set = 1; end
      else                         acc = 1;
    end
    if (m_vld && rdy_in) m_vld = 0;
    if (!m_vld && m_q.size() > 0) begin
      m_out = m_q.pop_front();
      m_vld = 1;
    end
    if (acc) m_q.push_back(w);
    if (wr_en && wr_addr == 16'h0040 && int'(wr_chan) < N_CHAN)
      m_dest[wr_chan[2:0]] = wr_data[4:0];
    if (wr_en && wr_addr == 16'h0041) begin
      m_ovf = 0;
      m_cnt = 0;
    end else begin
      if (ovf_set) m_ovf = 1;
      if (drop && m_cnt < 65535) m_cnt++;
    end
    #1;
    check("dv_out", dv_out, m_vld);
    if (m_vld) check("word", {dest_out, chan_out, data_out}, m_out);
    check("ovf_out", ovf_out, m_ovf);
    check("drop_cnt", drop_cnt_out, exp_cnt());
  endtask

  task automatic cfg(input int ch, input logic [4:0] dest);
    wr_en = 1; wr_addr = 16'h0040; wr_chan = 16'(ch); wr_data = {43'd0, dest};
    step();
    wr_en = 0;
  endtask

  task automatic ovf_clear();
    wr_en = 1; wr_addr = 16'h0041; wr_chan = 16'hFFFF; wr_data = '0;
    step();
    wr_en = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset ----------------
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_dv", dv_out, 0);
    check("rst_word", {dest_out, chan_out, data_out}, 0);
    check("rst_ovf", ovf_out, 0);
    check("rst_cnt", drop_cnt_out, 0);
    #1 rst_n_in = 1;

    // ---------------- 2-cycle latency, one-cycle hold ----------------
    cfg(2, 5'd5);
    rdy_in = 1;
    dv_in = 1; chan_in = 5'd2; data_in = 18'h1234;
    step();
    dv_in = 0;
    check("lat_edge_n", dv_out, 0);
    step();
    check("lat_edge_n1", dv_out, 1);
    check("lat_word", {dest_out, chan_out, data_out}, {4'd5, 5'd2, 18'h01234});
    step();
    check("lat_held_one", dv_out, 0);

    // ---------------- unmapped channel ----------------
    for (int i = 0; i < 3; i++) begin
      dv_in = 1; chan_in = 5'd3; data_in = 18'(i);
      step();
    end
    dv_in = 0;
    step(); step();
    check("null_dv", dv_out, 0);
    check("null_ovf", ovf_out, 0);
    check("null_cnt", drop_cnt_out, CNT_EN ? 16'd3 : 16'd0);

    // ---------------- overflow ----------------
    cfg(4, 5'd1);
    rdy_in = 0;
    obs.delete();
    for (int i = 0; i < 18; i++) begin
      dv_in = 1; chan_in = 5'd4; data_in = 18'(100 + i);
      step();
    end
    dv_in = 0;
    check("ovf_set", ovf_out, 1);
    check("ovf_cnt", drop_cnt_out, CNT_EN ? 16'd4 : 16'd0);
    rdy_in = 1;
    repeat (20) step();
    check("ovf_count_out", obs.size(), 17);
    for (int i = 0; i < obs.size(); i++) check("ovf_order", obs[i].data, 18'(100 + i));
    ovf_clear();
    check("ovf_clr", ovf_out, 0);
    check("ovf_clr_cnt", drop_cnt_out, 0);

    // ---------------- remap does not retag queued words ----------------
    cfg(1, 5'd2);
    obs.delete();
    dv_in = 1; chan_in = 5'd1; data_in = 18'hA; step(); dv_in = 0;
    cfg(1, 5'd7);
    dv_in = 1; chan_in = 5'd1; data_in = 18'hB; step();
    // config write and word on the same edge: word keeps the old tag (7)
    wr_en = 1; wr_addr = 16'h0040; wr_chan = 16'd1; wr_data = 48'd2;
    data_in = 18'hC; step();
    wr_en = 0;
    data_in = 18'hD; step();
    dv_in = 0;
    repeat (5) step();
    check("remap_n", obs.size(), 4);
    if (obs.size() == 4) begin
      check("remap_a", {obs[0].dest, obs[0].data}, {4'd2, 18'hA});
      check("remap_b", {obs[1].dest, obs[1].data}, {4'd7, 18'hB});
      check("remap_c", {obs[2].dest, obs[2].data}, {4'd7, 18'hC});
      check("remap_d", {obs[3].dest, obs[3].data}, {4'd2, 18'hD});
    end

    // ---------------- toggled ready ----------------
    obs.delete();
    for (int i = 0; i < 10; i++) begin
      dv_in = 1; chan_in = 5'd2; data_in = 18'(200 + i); rdy_in = i[0];
      step();
    end
    dv_in = 0;
    for (int i = 0; i < 30; i++) begin
      rdy_in = i[0];
      step();
    end
    check("toggle_n", obs.size(), 10);
    for (int i = 0; i < obs.size(); i++) check("toggle_order", obs[i].data, 18'(200 + i));

    // ---------------- randomized traffic ----------------
    for (int cyc = 0; cyc < 2000; cyc++) begin
      dv_in   = ($urandom % 4) != 0;
      chan_in = 5'($urandom % 10);
      data_in = 18'($urandom);
      rdy_in  = ((cyc / 200) % 2 == 1) ? ($urandom % 8 == 0) : ($urandom % 3 != 0);
      wr_en   = ($urandom % 16) == 0;
      case ($urandom % 8)
        0:       wr_addr = 16'h0041;
        1:       wr_addr = 16'h0042;
        default: wr_addr = 16'h0040;
      endcase
      wr_chan = 16'($urandom % 10);
      wr_data = {$urandom, $urandom} & 48'h0000_FFFF_FFFF;
      if ($urandom % 4 == 0) wr_data[4:0] = 5'h10;
      step();
    end
    dv_in = 0; wr_en = 0; rdy_in = 1;
    repeat (20) step();

    // ---------------- asynchronous reset mid-burst ----------------
    cfg(2, 5'd6);
    for (int i = 0; i < 4; i++) begin
      dv_in = 1; chan_in = 5'd2; data_in = 18'(300 + i);
      step();
    end
    check("pre_rst_dv", dv_out, 1);
    #2;
    rst_n_in = 0; dv_in = 0; wr_en = 0;
    #1;
    check("rst_async_dv", dv_out, 0);
    check("rst_async_word", {dest_out, chan_out, data_out}, 0);
    model_reset();
    obs.delete();
    @(posedge clk_in);
    #2 rst_n_in = 1;
    repeat (3) step();
    check("post_rst_empty", dv_out, 0);
    for (int c = 0; c < N_CHAN; c++) begin
      dv_in = 1; chan_in = 5'(c); data_in = 18'(400 + c);
      step();
    end
    dv_in = 0;
    repeat (4) step();
    check("post_rst_null_dv", obs.size(), 0);
    check("post_rst_null_cnt", drop_cnt_out, CNT_EN ? 16'd8 : 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
